commit_unit: RTL and testbench
==============================

Name: commit_unit

Overview:
- In-order retirement stage; the reader and drainer for the speculative instruction buffer.
- Each cycle it inspects the two oldest buffer entries, entries[0] and entries[1], and retires up to two of them.
- It drives register-file writes and performs stores through a memory write handshake.
- It returns is_really_commited, is_commited_store and commited_tags, which make the buffer slide its queue forward.

Parameters:
BUF_SIZE_LOG, 4, log2 of buffer depth; must match the buffer.
BUF_SIZE, 2**BUF_SIZE_LOG, number of buffer entries.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
entries  input  entry_t x BUF_SIZE  current buffer contents; only indexes 0 and 1 are read.
is_really_commited  output  bool x 2  slot k retires this cycle.
is_commited_store  output  bool x 2  retiring slot k is a store.
commited_tags  output  tag_t x 2  tag of retiring slot k; 0 when that slot is not retiring.
rf_we  output  1 x 2  register write enable per slot.
rf_waddr  output  5 x 2  destination register (Dest).
rf_wdata  output  32 x 2  result value.
mem_req  output  1  store write request.
mem_addr  output  32  store address (A of entries[0]).
mem_wdata  output  32  store data (Vk of entries[0]).
mem_mode  output  ldst_mode_t  store width (rwmm of entries[0]).
mem_ack  input  1  memory accepted the write this cycle.
retired_count  output  32  total instructions retired, registered.

Behaviour:
- An entry e is committable when e.e_state == S_EXECUTED and e.speculative_tag == 0.
- Outputs are combinational from entries plus registered FSM state; the buffer consumes them in the same cycle.
- FSM states: C_IDLE and C_STORE_WAIT. Reset state is C_IDLE.
- In C_IDLE, when entries[0] is committable and not a STORE:
  - slot 0 retires.
  - slot 1 also retires only if entries[1] is committable and entries[1].Unit != STORE.
- In C_IDLE, when entries[0] is committable and a STORE:
  - nothing retires this cycle.
  - next state is C_STORE_WAIT.
- In C_STORE_WAIT:
  - mem_req = 1; mem_addr, mem_wdata and mem_mode are taken from entries[0].
  - Without mem_ack: stay in C_STORE_WAIT; nothing retires.
  - On mem_ack: slot 0 retires with is_commited_store[0]=true, slot 1 does not retire, next state is C_IDLE.
- Store latency: a committable store at the head produces mem_req one cycle later. Retirement happens in the mem_ack cycle. Minimum of 2 cycles per store.
- Slot 1 never retires unless slot 0 also retires; is_really_commited[1] implies is_really_commited[0].
- A store in slot 1 always waits until it reaches slot 0.
- Register write for retiring slot k: rf_we[k] = 1 iff Unit != STORE and Dest != 0. Then rf_waddr[k] = Dest and rf_wdata[k] = result.
- When rf_we[k] = 0, rf_waddr[k] and rf_wdata[k] are 0.
- Two retiring writes to the same Dest: slot 1 is the younger and wins. The register file must give port 1 priority.
- If mem_req is 0, mem_addr, mem_wdata and mem_mode are 0.
- commited_tags[k] passes entries[k].tag through unchanged, including any tag-flood MSB.
- retired_count adds the number of retiring slots (0/1/2) every cycle and wraps modulo 2^32.
- Reset values:
  - state C_IDLE, retired_count 0.
  - all combinational outputs evaluate to 0/false, because reset clears the buffer to S_NOT_USED.
- Reset while in C_STORE_WAIT: return to C_IDLE, mem_req drops the next cycle, no retirement is reported.
- Empty or unexecuted head (S_NOT_USED, S_NOT_EXECUTED, S_EXECUTING, S_ADDR_GENERATED): nothing retires.
- A speculative head (speculative_tag != 0) never retires, even if executed; it waits for the branch to resolve.
- A head store can never be flushed while in C_STORE_WAIT, because it is non-speculative. The implementation must not rely on the head changing during C_STORE_WAIT.

Test Plan:
- ALU x5 result 7 at entries[0] and ALU x6 result 9 at entries[1], both S_EXECUTED with speculative_tag 0 -> both slots retire; rf writes (5,7) and (6,9); retired_count +2.
- entries[0] executed with Dest=0, entries[1] S_EXECUTING -> only slot 0 retires, with rf_we[0]=0; commited_tags[1]=0.
- Head STORE with A=0x100, Vk=0xAB, rwmm=BYTE, and mem_ack delayed 3 cycles -> mem_req rises in cycle 1 and holds with addr 0x100, data 0xAB, mode BYTE; retirement with is_commited_store[0]=true occurs only in the ack cycle; no slot-1 retirement.
- Head executed but speculative_tag=6'b000001 -> no retirement; after the tag clears to 0 -> retires that cycle.
- Slot 0 ALU and slot 1 STORE, both committable -> only slot 0 retires; next cycle the store enters C_STORE_WAIT.
- Reset asserted during C_STORE_WAIT -> mem_req is 0 the next cycle, state is C_IDLE, retired_count is 0.

Source files
------------

// File: rtl/commit_unit.sv
`default_nettype none
//==============================================================================
// Module      : commit_unit (with commit_pkg)
// Description : In-order retirement stage. Inspects the two oldest entries of
//               the speculative instruction buffer, retires up to two per
//               cycle, drives register-file writes and performs head stores
//               through a memory write handshake.
// Revision    : 1.0 - initial release
//==============================================================================

package commit_pkg;

   typedef enum logic [2:0] {
      S_NOT_USED       = 3'd0,
      S_NOT_EXECUTED   = 3'd1,
      S_EXECUTING      = 3'd2,
      S_ADDR_GENERATED = 3'd3,
      S_EXECUTED       = 3'd4
   } e_state_t;

   typedef enum logic [1:0] {
      ALU    = 2'd0,
      BRANCH = 2'd1,
      LOAD   = 2'd2,
      STORE  = 2'd3
   } unit_t;

   // Zero encoding is reserved so an idle memory port reads as all-zero.
   typedef enum logic [1:0] {
      LS_NONE = 2'd0,
      BYTE    = 2'd1,
      HALF    = 2'd2,
      WORD    = 2'd3
   } ldst_mode_t;

   // Buffer index plus the tag-flood MSB.
   typedef logic [4:0] tag_t;
   typedef logic [5:0] spec_tag_t;

   typedef struct packed {
      e_state_t   e_state;
      unit_t      Unit;
      logic [4:0] Dest;
      logic [31:0] result;
      logic [31:0] A;
      logic [31:0] Vk;
      ldst_mode_t rwmm;
      spec_tag_t  speculative_tag;
      tag_t       tag;
   } entry_t;

endpackage

module commit_unit
   import commit_pkg::*;
#(
   parameter int BUF_SIZE_LOG = 4,
   parameter int BUF_SIZE     = 2**BUF_SIZE_LOG
) (
   input  logic                clk,
   input  logic                reset,
   input  entry_t              entries [BUF_SIZE],
   output logic [1:0]          is_really_commited,
   output logic [1:0]          is_commited_store,
   output tag_t [1:0]          commited_tags,
   output logic [1:0]          rf_we,
   output logic [1:0][4:0]     rf_waddr,
   output logic [1:0][31:0]    rf_wdata,
   output logic                mem_req,
   output logic [31:0]         mem_addr,
   output logic [31:0]         mem_wdata,
   output ldst_mode_t          mem_mode,
   input  logic                mem_ack,
   output logic [31:0]         retired_count
);

   typedef enum logic [0:0] {
      C_IDLE       = 1'b0,
      C_STORE_WAIT = 1'b1
   } cstate_t;

   cstate_t     r_state;
   cstate_t     w_next;
   logic [1:0]  w_ret;
   logic        w_store0;
   logic        w_commit0;
   logic        w_commit1;
   logic [31:0] r_retired_count;

   // Only entries[0] and entries[1] matter; fold the rest so nothing dangles.
   logic [BUF_SIZE-1:0] w_unused_fold;
   generate
      for (genvar gi = 0; gi < BUF_SIZE; gi++) begin : g_unused
         assign w_unused_fold[gi] = ^entries[gi];
      end
   endgenerate

   assign w_commit0 = (entries[0].e_state == S_EXECUTED) && (entries[0].speculative_tag == '0);
   assign w_commit1 = (entries[1].e_state == S_EXECUTED) && (entries[1].speculative_tag == '0);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= C_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and retirement decision; a store only retires on its ack.
   always_comb begin
      w_next    = r_state;
      w_ret     = 2'b00;
      w_store0  = 1'b0;
      mem_req   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_mode  = LS_NONE;
      case (r_state)
         C_IDLE: begin
            if (w_commit0) begin
               if (entries[0].Unit == STORE) begin
                  w_next = C_STORE_WAIT;
               end else begin
                  w_ret[0] = 1'b1;
                  w_ret[1] = w_commit1 && (entries[1].Unit != STORE);
               end
            end
         end
         C_STORE_WAIT: begin
            mem_req   = 1'b1;
            mem_addr  = entries[0].A;
            mem_wdata = entries[0].Vk;
            mem_mode  = entries[0].rwmm;
            if (mem_ack) begin
               w_ret[0] = 1'b1;
               w_store0 = 1'b1;
               w_next   = C_IDLE;
            end
         end
         default: w_next = C_IDLE;
      endcase
      // The buffer is being cleared during reset; report no retirement.
      if (reset) begin
         w_ret    = 2'b00;
         w_store0 = 1'b0;
      end
   end

   // Per-slot retirement outputs and register-file write port.
   always_comb begin
      is_really_commited = w_ret;
      is_commited_store  = {1'b0, w_store0};
      for (int k = 0; k < 2; k++) begin
         commited_tags[k] = '0;
         rf_we[k]         = 1'b0;
         rf_waddr[k]      = '0;
         rf_wdata[k]      = '0;
         if (w_ret[k]) begin
            commited_tags[k] = entries[k].tag;
            if ((entries[k].Unit != STORE) && (entries[k].Dest != 5'd0)) begin
               rf_we[k]    = 1'b1;
               rf_waddr[k] = entries[k].Dest;
               rf_wdata[k] = entries[k].result;
            end
         end
      end
   end

   // Running count of retired instructions, wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) r_retired_count <= '0;
      else       r_retired_count <= r_retired_count + 32'(w_ret[0]) + 32'(w_ret[1]);
   end

   assign retired_count = r_retired_count;

endmodule
`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_commit_unit
// Description : Directed self-checking bench for commit_unit.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_commit_unit;
   import commit_pkg::*;

   localparam int BUF_SIZE = 16;

   logic            clk;
   logic            reset;
   entry_t          entries [BUF_SIZE];
   logic [1:0]      is_really_commited;
   logic [1:0]      is_commited_store;
   tag_t [1:0]      commited_tags;
   logic [1:0]      rf_we;
   logic [1:0][4:0] rf_waddr;
   logic [1:0][31:0] rf_wdata;
   logic            mem_req;
   logic [31:0]     mem_addr;
   logic [31:0]     mem_wdata;
   ldst_mode_t      mem_mode;
   logic            mem_ack;
   logic [31:0]     retired_count;

   int errors = 0;
   int checks = 0;

   commit_unit #(.BUF_SIZE_LOG(4)) dut (
      .clk(clk), .reset(reset), .entries(entries),
      .is_really_commited(is_really_commited), .is_commited_store(is_commited_store),
      .commited_tags(commited_tags), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_mode(mem_mode), .mem_ack(mem_ack),
      .retired_count(retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   function automatic entry_t mk(input e_state_t st, input unit_t u, input logic [4:0] d,
                                 input logic [31:0] res, input logic [31:0] a,
                                 input logic [31:0] vk, input ldst_mode_t m,
                                 input spec_tag_t sp, input tag_t t);
      entry_t e;
      e.e_state = st; e.Unit = u; e.Dest = d; e.result = res; e.A = a;
      e.Vk = vk; e.rwmm = m; e.speculative_tag = sp; e.tag = t;
      return e;
   endfunction

   task automatic clear_entries();
      for (int i = 0; i < BUF_SIZE; i++) entries[i] = '0;
   endtask

   // Advance one clock and settle just past the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset   = 1'b1;
      mem_ack = 1'b0;
      clear_entries();
      step();
      step();
      check("rst_count", retired_count, 32'd0);
      check("rst_memreq", 32'(mem_req), 32'd0);
      check("rst_ret", 32'(is_really_commited), 32'd0);
      check("rst_mode", 32'(mem_mode), 32'd0);
      reset = 1'b0;

      // Two ALU ops retire together.
      entries[0] = mk(S_EXECUTED, ALU, 5'd5, 32'd7, 0, 0, LS_NONE, 6'd0, 5'd1);
      entries[1] = mk(S_EXECUTED, ALU, 5'd6, 32'd9, 0, 0, LS_NONE, 6'd0, 5'd18);
      #1;
      check("dual_ret", 32'(is_really_commited), 32'h3);
      check("dual_we", 32'(rf_we), 32'h3);
      check("dual_waddr0", 32'(rf_waddr[0]), 32'd5);
      check("dual_wdata0", rf_wdata[0], 32'd7);
      check("dual_waddr1", 32'(rf_waddr[1]), 32'd6);
      check("dual_wdata1", rf_wdata[1], 32'd9);
      check("dual_tag1", 32'(commited_tags[1]), 32'd18);
      step();
      check("dual_count", retired_count, 32'd2);

      // Dest 0 head retires without a write; slot 1 not executed.
      entries[0] = mk(S_EXECUTED, ALU, 5'd0, 32'd11, 0, 0, LS_NONE, 6'd0, 5'd3);
      entries[1] = mk(S_EXECUTING, ALU, 5'd7, 32'd12, 0, 0, LS_NONE, 6'd0, 5'd4);
      #1;
      check("x0_ret", 32'(is_really_commited), 32'h1);
      check("x0_we", 32'(rf_we), 32'h0);
      check("x0_waddr0", 32'(rf_waddr[0]), 32'd0);
      check("x0_wdata0", rf_wdata[0], 32'd0);
      check("x0_tag0", 32'(commited_tags[0]), 32'd3);
      check("x0_tag1", 32'(commited_tags[1]), 32'd0);
      step();
      check("x0_count", retired_count, 32'd3);

      // Head store with the ack arriving in the third wait cycle.
      entries[0] = mk(S_EXECUTED, STORE, 5'd0, 0, 32'h100, 32'hAB, BYTE, 6'd0, 5'd7);
      entries[1] = mk(S_EXECUTED, ALU, 5'd9, 32'd1, 0, 0, LS_NONE, 6'd0, 5'd8);
      #1;
      check("st_c0_ret", 32'(is_really_commited), 32'h0);
      check("st_c0_req", 32'(mem_req), 32'd0);
      step();
      check("st_c1_req", 32'(mem_req), 32'd1);
      check("st_c1_addr", mem_addr, 32'h100);
      check("st_c1_data", mem_wdata, 32'hAB);
      check("st_c1_mode", 32'(mem_mode), 32'(BYTE));
      check("st_c1_ret", 32'(is_really_commited), 32'h0);
      check("st_c1_store", 32'(is_commited_store), 32'h0);
      step();
      check("st_c2_req", 32'(mem_req), 32'd1);
      check("st_c2_ret", 32'(is_really_commited), 32'h0);
      step();
      mem_ack = 1'b1;
      #1;
      check("st_ack_req", 32'(mem_req), 32'd1);
      check("st_ack_ret", 32'(is_really_commited), 32'h1);
      check("st_ack_store", 32'(is_commited_store), 32'h1);
      check("st_ack_tag0", 32'(commited_tags[0]), 32'd7);
      check("st_ack_we", 32'(rf_we), 32'h0);
      check("st_count_pre", retired_count, 32'd3);
      step();
      mem_ack = 1'b0;
      clear_entries();
      #1;
      check("st_count", retired_count, 32'd4);
      check("st_idle_req", 32'(mem_req), 32'd0);
      check("st_idle_addr", mem_addr, 32'd0);

      // Speculative head waits until its tag clears.
      entries[0] = mk(S_EXECUTED, ALU, 5'd3, 32'h55, 0, 0, LS_NONE, 6'b000001, 5'd10);
      #1;
      check("spec_ret", 32'(is_really_commited), 32'h0);
      check("spec_we", 32'(rf_we), 32'h0);
      step();
      check("spec_count", retired_count, 32'd4);
      entries[0].speculative_tag = 6'd0;
      #1;
      check("unspec_ret", 32'(is_really_commited), 32'h1);
      check("unspec_waddr", 32'(rf_waddr[0]), 32'd3);
      check("unspec_wdata", rf_wdata[0], 32'h55);
      step();
      check("unspec_count", retired_count, 32'd5);

      // ALU head with a store behind it: only the ALU retires.
      entries[0] = mk(S_EXECUTED, ALU, 5'd8, 32'd1, 0, 0, LS_NONE, 6'd0, 5'd11);
      entries[1] = mk(S_EXECUTED, STORE, 5'd0, 0, 32'h200, 32'hCD, WORD, 6'd0, 5'd12);
      #1;
      check("alust_ret", 32'(is_really_commited), 32'h1);
      check("alust_tag1", 32'(commited_tags[1]), 32'd0);
      step();
      check("alust_count", retired_count, 32'd6);
      entries[0] = entries[1];
      entries[1] = '0;
      #1;
      check("alust_hd_ret", 32'(is_really_commited), 32'h0);
      check("alust_hd_req", 32'(mem_req), 32'd0);
      step();
      check("alust_wait_req", 32'(mem_req), 32'd1);
      check("alust_wait_mode", 32'(mem_mode), 32'(WORD));

      // Reset in the store wait state.
      reset = 1'b1;
      clear_entries();
      #1;
      check("rstw_ret", 32'(is_really_commited), 32'h0);
      step();
      reset = 1'b0;
      #1;
      check("rstw_req", 32'(mem_req), 32'd0);
      check("rstw_count", retired_count, 32'd0);

      // Back in idle: same destination in both slots, slot 1 carries younger data.
      entries[0] = mk(S_EXECUTED, ALU, 5'd4, 32'd1, 0, 0, LS_NONE, 6'd0, 5'd16);
      entries[1] = mk(S_EXECUTED, LOAD, 5'd4, 32'd2, 0, 0, LS_NONE, 6'd0, 5'd17);
      #1;
      check("same_ret", 32'(is_really_commited), 32'h3);
      check("same_we", 32'(rf_we), 32'h3);
      check("same_waddr1", 32'(rf_waddr[1]), 32'd4);
      check("same_wdata1", rf_wdata[1], 32'd2);
      check("same_tag0", 32'(commited_tags[0]), 32'd16);
      step();
      check("same_count", retired_count, 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
